// File: rtl/spc_pkg.sv
// rtl/spc_pkg.sv - shared SPC700 RAM arbiter types and width constants
package spc_pkg;

  localparam int SPC_ADDR_WIDTH = 16;
  localparam int SPC_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } arb_state_t;

  typedef enum logic {
    REQ_DSP = 1'b0,
    REQ_CPU = 1'b1
  } req_id_t;

endpackage

// File: rtl/ram_arb_select.sv
// rtl/ram_arb_select.sv - DSP-priority grant decision with CPU starvation guard
module ram_arb_select
  import spc_pkg::*;
#(
  parameter int MAX_DSP_STREAK = 4,
  parameter int STREAK_WIDTH   = $clog2(MAX_DSP_STREAK + 1)
) (
  input  logic                    dsp_req,
  input  logic                    cpu_req,
  input  logic [STREAK_WIDTH-1:0] streak,
  output req_id_t                 grant_id,
  output logic                    grant_valid
);

  always_comb begin
    grant_valid = dsp_req | cpu_req;
    grant_id    = REQ_DSP;
    // The CPU wins outright when alone, or once the DSP has used up its streak.
    if (cpu_req && (!dsp_req || streak == STREAK_WIDTH'(MAX_DSP_STREAK))) begin
      grant_id = REQ_CPU;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - two-requester (DSP/CPU) arbiter for the shared SPC700 RAM
module ram_arbiter
  import spc_pkg::*;
#(
  parameter int ADDR_WIDTH     = SPC_ADDR_WIDTH,
  parameter int DATA_WIDTH     = SPC_DATA_WIDTH,
  parameter int MAX_DSP_STREAK = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  dsp_req,
  input  logic                  dsp_we,
  input  logic [ADDR_WIDTH-1:0] dsp_address,
  input  logic [DATA_WIDTH-1:0] dsp_wdata,
  output logic                  dsp_ack,
  output logic [DATA_WIDTH-1:0] dsp_rdata,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_address,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_ack,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  output logic                  ram_write_enable,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic                  busy
);

  localparam int STREAK_WIDTH = $clog2(MAX_DSP_STREAK + 1);

  arb_state_t              state;
  req_id_t                 lat_id;
  logic                    lat_we;
  logic [STREAK_WIDTH-1:0] streak;

  req_id_t                 grant_id;
  logic                    grant_valid;
  logic                    sel_we;
  logic [ADDR_WIDTH-1:0]   sel_address;
  logic [DATA_WIDTH-1:0]   sel_wdata;

  ram_arb_select #(
    .MAX_DSP_STREAK(MAX_DSP_STREAK),
    .STREAK_WIDTH  (STREAK_WIDTH)
  ) u_select (
    .dsp_req    (dsp_req),
    .cpu_req    (cpu_req),
    .streak     (streak),
    .grant_id   (grant_id),
    .grant_valid(grant_valid)
  );

  always_comb begin
    sel_we      = dsp_we;
    sel_address = dsp_address;
    sel_wdata   = dsp_wdata;
    if (grant_id == REQ_CPU) begin
      sel_we      = cpu_we;
      sel_address = cpu_address;
      sel_wdata   = cpu_wdata;
    end
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clock) begin
    if (reset) begin
      state            <= IDLE;
      lat_id           <= REQ_DSP;
      lat_we           <= 1'b0;
      streak           <= '0;
      dsp_ack          <= 1'b0;
      cpu_ack          <= 1'b0;
      dsp_rdata        <= '0;
      cpu_rdata        <= '0;
      ram_address      <= '0;
      ram_wdata        <= '0;
      ram_write_enable <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (grant_valid) begin
            // ram_address/ram_wdata double as the latched request fields.
            lat_id           <= grant_id;
            lat_we           <= sel_we;
            ram_address      <= sel_address;
            ram_wdata        <= sel_wdata;
            ram_write_enable <= sel_we;
            state            <= ACCESS;
            if (!cpu_req || grant_id == REQ_CPU) begin
              streak <= '0;
            end else begin
              streak <= streak + STREAK_WIDTH'(1);
            end
          end
        end
        ACCESS: begin
          ram_write_enable <= 1'b0;
          state            <= DONE;
          if (lat_id == REQ_DSP) begin
            dsp_ack <= 1'b1;
            if (!lat_we) dsp_rdata <= ram_rdata;
          end else begin
            cpu_ack <= 1'b1;
            if (!lat_we) cpu_rdata <= ram_rdata;
          end
        end
        DONE: begin
          dsp_ack <= 1'b0;
          cpu_ack <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - directed bench for ram_arbiter with a behavioural RAM
module tb_ram_arbiter;

  logic        clock;
  logic        reset;
  logic        dsp_req, dsp_we, dsp_ack;
  logic [15:0] dsp_address;
  logic [7:0]  dsp_wdata, dsp_rdata;
  logic        cpu_req, cpu_we, cpu_ack;
  logic [15:0] cpu_address;
  logic [7:0]  cpu_wdata, cpu_rdata;
  logic [15:0] ram_address;
  logic [7:0]  ram_wdata, ram_rdata;
  logic        ram_write_enable;
  logic        busy;

  logic        pre_we;
  logic [15:0] pre_addr;
  logic [7:0]  pre_data;
  logic [7:0]  mem [0:65535];

  int checks = 0;
  int errors = 0;

  ram_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .MAX_DSP_STREAK(4)) dut (
    .clock(clock), .reset(reset),
    .dsp_req(dsp_req), .dsp_we(dsp_we), .dsp_address(dsp_address),
    .dsp_wdata(dsp_wdata), .dsp_ack(dsp_ack), .dsp_rdata(dsp_rdata),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_address(cpu_address),
    .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .ram_address(ram_address), .ram_wdata(ram_wdata),
    .ram_write_enable(ram_write_enable), .ram_rdata(ram_rdata), .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  assign ram_rdata = mem[ram_address];

  always @(posedge clock) begin
    if (ram_write_enable) mem[ram_address] <= ram_wdata;
    if (pre_we) mem[pre_addr] <= pre_data;
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic preload(input logic [15:0] a, input logic [7:0] d);
    pre_addr = a; pre_data = d; pre_we = 1'b1;
    step();
    pre_we = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    dsp_req = 1'b1; cpu_req = 1'b1;
    step();
    checks++;
    if ({dsp_ack, cpu_ack, busy, ram_write_enable} !== 4'b0) begin
      $display("FAIL reset_ctrl: got %b expected 0000", {dsp_ack, cpu_ack, busy, ram_write_enable});
      errors++;
    end
    checks++;
    if ({ram_address, ram_wdata, dsp_rdata, cpu_rdata} !== 40'h0) begin
      $display("FAIL reset_data: got %h expected 0", {ram_address, ram_wdata, dsp_rdata, cpu_rdata});
      errors++;
    end
    dsp_req = 1'b0; cpu_req = 1'b0;
    reset = 1'b0;
    step();
  endtask

  task automatic test_dsp_read();
    dsp_address = 16'h1234; dsp_we = 1'b0; dsp_req = 1'b1;
    step();
    dsp_req = 1'b0;
    checks++;
    if ({busy, ram_write_enable, dsp_ack, ram_address} !== {3'b100, 16'h1234}) begin
      $display("FAIL dsp_read_access: got %h expected %h", {busy, ram_write_enable, dsp_ack, ram_address}, {3'b100, 16'h1234});
      errors++;
    end
    step();
    checks++;
    if ({dsp_ack, cpu_ack, dsp_rdata} !== {2'b10, 8'hA5}) begin
      $display("FAIL dsp_read_done: got %h expected %h", {dsp_ack, cpu_ack, dsp_rdata}, {2'b10, 8'hA5});
      errors++;
    end
    step();
    checks++;
    if ({dsp_ack, cpu_ack, busy} !== 3'b000) begin
      $display("FAIL dsp_read_ack_pulse: got %b expected 000", {dsp_ack, cpu_ack, busy});
      errors++;
    end
  endtask

  task automatic test_cpu_write();
    cpu_address = 16'h00F0; cpu_we = 1'b1; cpu_wdata = 8'h5A; cpu_req = 1'b1;
    step();
    cpu_req = 1'b0;
    checks++;
    if ({ram_write_enable, ram_address, ram_wdata} !== {1'b1, 16'h00F0, 8'h5A}) begin
      $display("FAIL cpu_write_access: got %h expected %h", {ram_write_enable, ram_address, ram_wdata}, {1'b1, 16'h00F0, 8'h5A});
      errors++;
    end
    step();
    checks++;
    if ({ram_write_enable, cpu_ack, dsp_ack, cpu_rdata} !== {3'b010, 8'h00}) begin
      $display("FAIL cpu_write_done: got %h expected %h", {ram_write_enable, cpu_ack, dsp_ack, cpu_rdata}, {3'b010, 8'h00});
      errors++;
    end
    step();
    cpu_we = 1'b0; cpu_req = 1'b1;
    step();
    cpu_req = 1'b0;
    step();
    checks++;
    if ({cpu_ack, cpu_rdata, dsp_rdata} !== {1'b1, 8'h5A, 8'hA5}) begin
      $display("FAIL cpu_readback: got %h expected %h", {cpu_ack, cpu_rdata, dsp_rdata}, {1'b1, 8'h5A, 8'hA5});
      errors++;
    end
    step();
  endtask

  task automatic test_fairness();
    logic exp_cpu [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    int n = 0;
    int last = 0;
    dsp_address = 16'h1234; dsp_we = 1'b0;
    cpu_address = 16'h00F0; cpu_we = 1'b0;
    dsp_req = 1'b1; cpu_req = 1'b1;
    for (int cyc = 0; cyc < 40 && n < 10; cyc++) begin
      step();
      if (dsp_ack && cpu_ack) begin
        checks++;
        $display("FAIL fair_both_ack: got 11 expected one ack at cycle %0d", cyc);
        errors++;
      end else if (dsp_ack || cpu_ack) begin
        checks++;
        if (cpu_ack !== exp_cpu[n]) begin
          $display("FAIL fair_order[%0d]: got cpu=%b expected cpu=%b", n, cpu_ack, exp_cpu[n]);
          errors++;
        end
        if (n > 0) begin
          checks++;
          if (cyc - last != 3) begin
            $display("FAIL fair_spacing[%0d]: got %0d expected 3", n, cyc - last);
            errors++;
          end
        end
        last = cyc;
        n++;
      end
    end
    dsp_req = 1'b0; cpu_req = 1'b0;
    checks++;
    if (n != 10) begin
      $display("FAIL fair_timeout: got %0d grants expected 10", n);
      errors++;
    end
    step(); step();
  endtask

  task automatic test_simultaneous();
    int t_d = -1;
    int t_c = -1;
    dsp_address = 16'h1234; dsp_we = 1'b0;
    cpu_address = 16'h00F0; cpu_we = 1'b0;
    dsp_req = 1'b1; cpu_req = 1'b1;
    step();
    dsp_req = 1'b0;
    checks++;
    if (ram_address !== 16'h1234) begin
      $display("FAIL simul_first: got %h expected 1234", ram_address);
      errors++;
    end
    for (int cyc = 1; cyc < 12 && t_c < 0; cyc++) begin
      step();
      if (dsp_ack) t_d = cyc;
      if (cpu_ack) begin
        t_c = cyc;
        cpu_req = 1'b0;
      end
    end
    cpu_req = 1'b0;
    checks++;
    if (t_d != 1 || t_c - t_d != 3) begin
      $display("FAIL simul_timing: got dsp=%0d cpu=%0d expected dsp=1 cpu=4", t_d, t_c);
      errors++;
    end
    checks++;
    if ({dsp_rdata, cpu_rdata} !== 16'hA55A) begin
      $display("FAIL simul_rdata: got %h expected a55a", {dsp_rdata, cpu_rdata});
      errors++;
    end
    step();
  endtask

  task automatic test_reset_mid();
    cpu_address = 16'h0300; cpu_we = 1'b1; cpu_wdata = 8'h77; cpu_req = 1'b1;
    step();
    checks++;
    if (ram_write_enable !== 1'b1) begin
      $display("FAIL rmid_access: got %b expected 1", ram_write_enable);
      errors++;
    end
    reset = 1'b1;
    step();
    checks++;
    if ({dsp_ack, cpu_ack, busy, ram_write_enable, ram_address, ram_wdata, dsp_rdata, cpu_rdata} !== 44'h0) begin
      $display("FAIL rmid_outputs: got %h expected 0", {dsp_ack, cpu_ack, busy, ram_write_enable, ram_address, ram_wdata, dsp_rdata, cpu_rdata});
      errors++;
    end
    step();
    checks++;
    if (busy !== 1'b0) begin
      $display("FAIL rmid_req_ignored: got %b expected 0", busy);
      errors++;
    end
    reset = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if ({dsp_ack, cpu_ack, busy, ram_write_enable} !== 4'b0) begin
        $display("FAIL rmid_no_ack[%0d]: got %b expected 0000", i, {dsp_ack, cpu_ack, busy, ram_write_enable});
        errors++;
      end
    end
  endtask

  task automatic test_stability();
    dsp_address = 16'h0400; dsp_we = 1'b0; dsp_wdata = 8'h00; dsp_req = 1'b1;
    step();
    dsp_address = 16'h0500; dsp_we = 1'b1; dsp_wdata = 8'hFF; dsp_req = 1'b0;
    checks++;
    if ({ram_write_enable, ram_address} !== {1'b0, 16'h0400}) begin
      $display("FAIL stab_access: got %h expected %h", {ram_write_enable, ram_address}, {1'b0, 16'h0400});
      errors++;
    end
    step();
    checks++;
    if ({dsp_ack, dsp_rdata, ram_address} !== {1'b1, 8'h3C, 16'h0400}) begin
      $display("FAIL stab_done: got %h expected %h", {dsp_ack, dsp_rdata, ram_address}, {1'b1, 8'h3C, 16'h0400});
      errors++;
    end
    step();
    checks++;
    if ({busy, ram_address} !== {1'b0, 16'h0400}) begin
      $display("FAIL stab_hold: got %h expected %h", {busy, ram_address}, {1'b0, 16'h0400});
      errors++;
    end
    dsp_we = 1'b0; dsp_req = 1'b1;
    step();
    dsp_req = 1'b0;
    step();
    checks++;
    if ({dsp_ack, dsp_rdata} !== {1'b1, 8'hC3}) begin
      $display("FAIL stab_no_write: got %h expected %h", {dsp_ack, dsp_rdata}, {1'b1, 8'hC3});
      errors++;
    end
    step();
  endtask

  initial begin
    reset = 1'b1;
    dsp_req = 1'b0; dsp_we = 1'b0; dsp_address = '0; dsp_wdata = '0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_address = '0; cpu_wdata = '0;
    pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    preload(16'h1234, 8'hA5);
    preload(16'h00F0, 8'h00);
    preload(16'h0300, 8'h11);
    preload(16'h0400, 8'h3C);
    preload(16'h0500, 8'hC3);
    test_reset();
    test_dsp_read();
    test_cpu_write();
    test_fairness();
    test_simultaneous();
    test_reset_mid();
    test_stability();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
